lcd_stream_pic: RTL and testbench
=================================

LCD_STREAM_PIC -- requirements
Module: lcd_stream_pic

Interface
REQ-001 Parameter WIN_W, default 240: window width in pixels, range 1..320.
REQ-002 Parameter WIN_H, default 320: window height in pixels, range 1..320.
REQ-003 Parameter X0, default 0: window start column.
REQ-004 Parameter Y0, default 0: window start row.
REQ-005 Parameter HI_FIRST, default 1: 1 means the high byte of each pixel arrives first; 0 means the low byte arrives first.
REQ-006 Reset is sys_rst_n, asynchronous, active-low; clock is sys_clk.
REQ-007 sys_clk  in  1  system clock.
REQ-008 sys_rst_n  in  1  asynchronous active-low reset.
REQ-009 init_done  in  1  level; LCD initialisation complete; starts a frame.
REQ-010 wr_done  in  1  one-cycle pulse; the write engine has finished the current word.
REQ-011 recv_flag  in  1  one-cycle pulse; recv_data is valid.
REQ-012 recv_data  in  8  received pixel byte.
REQ-013 show_pic_data  out  9  bit8 = 0 for command, 1 for data; bits 7:0 carry the byte.
REQ-014 en_write_show_pic  out  1  one-cycle write request to the write engine.
REQ-015 show_pic_done  out  1  one-cycle pulse at frame end.
REQ-016 rx_overflow  out  1  sticky flag; a received byte was lost.

Function
REQ-017 The state machine SHALL use these states: IDLE, CASET, PASET, RAMWR, PIXEL, DONE.
- IDLE to CASET when init_done=1.
- DONE to IDLE after one cycle.
REQ-018 Each word SHALL follow a one-word handshake:
- en_write_show_pic pulses for 1 cycle with show_pic_data valid in that same cycle.
- show_pic_data is held until wr_done.
- The next request is issued no earlier than the cycle after wr_done.
- At most one request is outstanding.
REQ-019 CASET SHALL send 5 words: 9'h02A, X0[15:8], X0[7:0], XE[15:8], XE[7:0], with XE = X0+WIN_W-1 computed at 16 bits. After the 5th wr_done, go to PASET.
REQ-020 PASET SHALL send the same 5-word sequence with 9'h02B, Y0 and YE = Y0+WIN_H-1. Then go to RAMWR.
REQ-021 RAMWR SHALL send 9'h02C. On its wr_done, go to PIXEL.
REQ-022 PIXEL SHALL pop one byte from the receive buffer when it is non-empty and no request is outstanding, then issue {1'b1, byte}.
- Byte order on the bus is the arrival order.
- HI_FIRST controls only the parity used for pixel counting and for the frame-end check.
REQ-023 Pixel counting:
- Byte counter bit0 selects the half-pixel.
- col_cnt (0..WIN_W-1) increments on the wr_done of the second byte of each pixel.
- On wrap, col_cnt returns to 0 and row_cnt increments.
REQ-024 When the second byte of pixel (WIN_W-1, WIN_H-1) is acknowledged by wr_done, the block SHALL enter DONE.
- show_pic_done=1 in DONE.
- All counters clear.
REQ-025 Bytes received while not in PIXEL SHALL be written into the buffer, not dropped, while space remains.
REQ-026 A recv_flag arriving when the buffer is full SHALL set rx_overflow and discard the byte.
- rx_overflow clears only on reset or on entry to CASET.
REQ-027 A simultaneous recv_flag and pop on a full buffer SHALL be accepted with no overflow.
REQ-028 A wr_done arriving with no outstanding request SHALL be ignored.
REQ-029 An init_done that is still high after DONE SHALL start a new frame, so frames repeat.

Reset
REQ-030 On reset the block SHALL enter IDLE, with all counters, the buffer and rx_overflow cleared.
REQ-031 Reset values: show_pic_data=9'h000, en_write_show_pic=0, show_pic_done=0.
REQ-032 Reset asserted mid-frame SHALL abort the frame with no further requests; a new frame restarts from CASET.

Configuration
REQ-033 Macro LCD_STREAM_FIFO_EN defined: the receive buffer SHALL be a 16-entry byte FIFO.
REQ-034 Macro LCD_STREAM_FIFO_EN undefined: the receive buffer SHALL be a single-byte holding register with the same full/empty and overflow rules.

Structure
REQ-035 Package lcd_pkg SHALL hold:
- Command constants: CMD_CASET=8'h2A, CMD_PASET=8'h2B, CMD_RAMWR=8'h2C.
- The state encoding type.
- The colour constants.
REQ-036 Sub-module lcd_byte_fifo SHALL be used, parameterised by DEPTH, with ports: push, pop, din, dout, full, empty.

Verification
REQ-037 WIN_W=2, WIN_H=2, X0=10, Y0=20, immediate wr_done -> words 02A,000,00A,000,00B,02B,000,014,000,015,02C in order.
REQ-038 After RAMWR, stream 8 bytes A0..A7 -> data words 1A0..1A7 in order, and show_pic_done pulses once after the wr_done of A7.
REQ-039 wr_done delayed 5 cycles per word -> no second request while one is outstanding, and show_pic_data is stable throughout.
REQ-040 Without the FIFO macro, two recv_flag pulses with no pop -> rx_overflow=1 and the first byte is retained; with the macro, 16 bytes give no overflow and the 17th sets it.
REQ-041 Reset asserted mid-PIXEL with init_done held -> outputs at reset values, then a restart from word 02A.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD picture streaming path.
package lcd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CASET,
    PASET,
    RAMWR,
    PIXEL,
    DONE
  } lcd_state_e;

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_PASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  // RGB565 colours
  localparam logic [15:0] COLOR_BLACK = 16'h0000;
  localparam logic [15:0] COLOR_WHITE = 16'hFFFF;
  localparam logic [15:0] COLOR_RED   = 16'hF800;
  localparam logic [15:0] COLOR_GREEN = 16'h07E0;
  localparam logic [15:0] COLOR_BLUE  = 16'h001F;

  // Word idx of a 5-word address-window sequence: cmd, start hi/lo, end hi/lo.
  function automatic logic [8:0] win_word(input logic [7:0]  cmd,
                                          input logic [15:0] first,
                                          input logic [15:0] last,
                                          input logic [2:0]  idx);
    logic [8:0] w;
    w = 9'h000;
    case (idx)
      3'd0:    w = {1'b0, cmd};
      3'd1:    w = {1'b0, first[15:8]};
      3'd2:    w = {1'b0, first[7:0]};
      3'd3:    w = {1'b0, last[15:8]};
      3'd4:    w = {1'b0, last[7:0]};
      default: w = 9'h000;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/lcd_byte_fifo.sv
// Receive byte buffer: a holding register when DEPTH is 1, otherwise a ring FIFO.
// First-word-fall-through: dout is valid whenever empty is low.
module lcd_byte_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  if (DEPTH == 1) begin : g_hold
    logic [7:0] hold_q;
    logic       vld_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        hold_q <= 8'h00;
        vld_q  <= 1'b0;
      end else begin
        if (push && (!vld_q || pop)) begin
          hold_q <= din;
          vld_q  <= 1'b1;
        end else if (pop) begin
          vld_q  <= 1'b0;
        end
      end
    end

    assign dout  = hold_q;
    assign full  = vld_q;
    assign empty = !vld_q;
  end else begin : g_ring
    localparam int unsigned AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full buffer is legal when the same cycle frees a slot.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rptr_q];

    always_ff @(posedge sys_clk) begin
      if (do_push) mem[wptr_q] <= din;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        wptr_q <= '0;
        rptr_q <= '0;
        cnt_q  <= '0;
      end else begin
        if (do_push) wptr_q <= (wptr_q == AW'(DEPTH-1)) ? '0 : wptr_q + 1'b1;
        if (do_pop)  rptr_q <= (rptr_q == AW'(DEPTH-1)) ? '0 : rptr_q + 1'b1;
        case ({do_push, do_pop})
          2'b10:   cnt_q <= cnt_q + 1'b1;
          2'b01:   cnt_q <= cnt_q - 1'b1;
          default: cnt_q <= cnt_q;
        endcase
      end
    end
  end

endmodule

// File: rtl/lcd_stream_pic.sv
// Streams received pixel bytes into an LCD window (CASET/PASET/RAMWR then pixel data).
// Define LCD_STREAM_FIFO_EN for a 16-entry receive FIFO; otherwise a single-byte holding register.
module lcd_stream_pic
  import lcd_pkg::*;
#(
  parameter int unsigned WIN_W    = 240,
  parameter int unsigned WIN_H    = 320,
  parameter int unsigned X0       = 0,
  parameter int unsigned Y0       = 0,
  parameter int unsigned HI_FIRST = 1
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       init_done,
  input  logic       wr_done,
  input  logic       recv_flag,
  input  logic [7:0] recv_data,
  output logic [8:0] show_pic_data,
  output logic       en_write_show_pic,
  output logic       show_pic_done,
  output logic       rx_overflow
);

`ifdef LCD_STREAM_FIFO_EN
  localparam int unsigned BUF_DEPTH = 16;
`else
  localparam int unsigned BUF_DEPTH = 1;
`endif

  localparam logic [15:0] XS       = 16'(X0);
  localparam logic [15:0] XE       = 16'(X0 + WIN_W - 1);
  localparam logic [15:0] YS       = 16'(Y0);
  localparam logic [15:0] YE       = 16'(Y0 + WIN_H - 1);
  localparam logic [8:0]  COL_LAST = 9'(WIN_W - 1);
  localparam logic [8:0]  ROW_LAST = 9'(WIN_H - 1);
  localparam logic        HI_BIT   = (HI_FIRST != 0);

  lcd_state_e state;
  logic       busy;
  logic [2:0] widx;
  logic [8:0] col_cnt, row_cnt;
  logic       byte_cnt;

  logic       buf_push, buf_pop, buf_full, buf_empty;
  logic [7:0] buf_dout;
  logic       lo_half, is_second;

  assign buf_pop  = (state == PIXEL) && !busy && !buf_empty;
  assign buf_push = recv_flag && (!buf_full || buf_pop);

  // lo_half marks the low byte of the pixel on the bus; the closing byte is the later one.
  assign lo_half   = byte_cnt ^ ~HI_BIT;
  assign is_second = HI_BIT ? lo_half : ~lo_half;

  lcd_byte_fifo #(
    .DEPTH(BUF_DEPTH)
  ) u_rx_buf (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .push     (buf_push),
    .pop      (buf_pop),
    .din      (recv_data),
    .dout     (buf_dout),
    .full     (buf_full),
    .empty    (buf_empty)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state             <= IDLE;
      busy              <= 1'b0;
      widx              <= 3'd0;
      col_cnt           <= 9'd0;
      row_cnt           <= 9'd0;
      byte_cnt          <= 1'b0;
      show_pic_data     <= 9'h000;
      en_write_show_pic <= 1'b0;
      show_pic_done     <= 1'b0;
      rx_overflow       <= 1'b0;
    end else begin
      en_write_show_pic <= 1'b0;
      show_pic_done     <= 1'b0;
      unique case (state)
        IDLE: begin
          if (init_done) begin
            state       <= CASET;
            widx        <= 3'd0;
            rx_overflow <= 1'b0;
          end
        end
        CASET, PASET: begin
          if (!busy) begin
            show_pic_data     <= (state == CASET) ? win_word(CMD_CASET, XS, XE, widx)
                                                  : win_word(CMD_PASET, YS, YE, widx);
            en_write_show_pic <= 1'b1;
            busy              <= 1'b1;
          end else if (wr_done) begin
            busy <= 1'b0;
            if (widx == 3'd4) begin
              widx  <= 3'd0;
              state <= (state == CASET) ? PASET : RAMWR;
            end else begin
              widx <= widx + 3'd1;
            end
          end
        end
        RAMWR: begin
          if (!busy) begin
            show_pic_data     <= {1'b0, CMD_RAMWR};
            en_write_show_pic <= 1'b1;
            busy              <= 1'b1;
          end else if (wr_done) begin
            busy  <= 1'b0;
            state <= PIXEL;
          end
        end
        PIXEL: begin
          if (buf_pop) begin
            show_pic_data     <= {1'b1, buf_dout};
            en_write_show_pic <= 1'b1;
            busy              <= 1'b1;
          end else if (busy && wr_done) begin
            busy     <= 1'b0;
            byte_cnt <= ~byte_cnt;
            if (is_second) begin
              if (col_cnt == COL_LAST) begin
                col_cnt <= 9'd0;
                if (row_cnt == ROW_LAST) begin
                  row_cnt       <= 9'd0;
                  byte_cnt      <= 1'b0;
                  state         <= DONE;
                  show_pic_done <= 1'b1;
                end else begin
                  row_cnt <= row_cnt + 9'd1;
                end
              end else begin
                col_cnt <= col_cnt + 9'd1;
              end
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
      // Lost byte: buffer full and no pop freeing a slot this cycle.
      if (recv_flag && buf_full && !buf_pop) rx_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lcd_stream_pic.sv
// Directed bench for lcd_stream_pic with a small 2x2 window at (10,20).
module tb_lcd_stream_pic;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       init_done = 1'b0;
  logic       wr_done = 1'b0;
  logic       recv_flag = 1'b0;
  logic [7:0] recv_data = 8'h00;
  logic [8:0] show_pic_data;
  logic       en_write_show_pic;
  logic       show_pic_done;
  logic       rx_overflow;

  int total = 0;
  int bad = 0;

  logic [8:0] words[$];
  int         ack_delay = 0;
  int         wait_cnt = 0;
  bit         outstanding = 0;
  logic [8:0] held = 9'h000;
  int         multi_req = 0;
  int         unstable = 0;
  int         done_cnt = 0;

  logic [8:0] hdr [11] = '{9'h02A, 9'h000, 9'h00A, 9'h000, 9'h00B,
                           9'h02B, 9'h000, 9'h014, 9'h000, 9'h015, 9'h02C};

`ifdef LCD_STREAM_FIFO_EN
  localparam int OVF_N = 17;
`else
  localparam int OVF_N = 2;
`endif

  lcd_stream_pic #(
    .WIN_W   (2),
    .WIN_H   (2),
    .X0      (10),
    .Y0      (20),
    .HI_FIRST(1)
  ) dut (
    .sys_clk          (sys_clk),
    .sys_rst_n        (sys_rst_n),
    .init_done        (init_done),
    .wr_done          (wr_done),
    .recv_flag        (recv_flag),
    .recv_data        (recv_data),
    .show_pic_data    (show_pic_data),
    .en_write_show_pic(en_write_show_pic),
    .show_pic_done    (show_pic_done),
    .rx_overflow      (rx_overflow)
  );

  always #5 sys_clk = ~sys_clk;

  // Write-engine model: logs requests, acks after ack_delay cycles, watches the handshake.
  always @(negedge sys_clk) begin
    wr_done = 1'b0;
    if (!sys_rst_n) begin
      outstanding = 0;
    end else begin
      if (show_pic_done) done_cnt++;
      if (en_write_show_pic) begin
        if (outstanding) multi_req++;
        words.push_back(show_pic_data);
        held        = show_pic_data;
        outstanding = 1;
        wait_cnt    = ack_delay;
      end else if (outstanding && show_pic_data != held) begin
        unstable++;
      end
      if (outstanding) begin
        if (wait_cnt == 0) begin
          wr_done     = 1'b1;
          outstanding = 0;
        end else begin
          wait_cnt--;
        end
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_words(input int n);
    int k = 0;
    while (words.size() < n && k < 400) begin
      @(posedge sys_clk);
      k++;
    end
    if (words.size() < n) check_eq("wait_words", words.size(), n);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge sys_clk);
    recv_data = b;
    recv_flag = 1'b1;
    @(negedge sys_clk);
    recv_flag = 1'b0;
  endtask

  initial begin
    int n;
    repeat (3) @(negedge sys_clk);
    #1;
    check_eq("rst_data", show_pic_data, 9'h000);
    check_eq("rst_en", en_write_show_pic, 1'b0);
    check_eq("rst_done", show_pic_done, 1'b0);
    check_eq("rst_ovf", rx_overflow, 1'b0);

    sys_rst_n = 1'b1;
    repeat (4) @(posedge sys_clk);
    check_eq("idle_no_words", words.size(), 0);

    // Frame 1: immediate acks.
    init_done = 1'b1;
    wait_words(11);
    for (int i = 0; i < 11; i++)
      if (i < words.size()) check_eq($sformatf("hdr1_%0d", i), words[i], hdr[i]);
    for (int i = 0; i < 8; i++) begin
      send_byte(8'hA0 + 8'(i));
      wait_words(12 + i);
    end
    for (int i = 0; i < 8; i++)
      if (11 + i < words.size()) check_eq($sformatf("pix1_%0d", i), words[11 + i], 9'h1A0 + 9'(i));
    ack_delay = 5;
    repeat (6) @(posedge sys_clk);
    check_eq("done_once", done_cnt, 1);

    // Frame 2 restarts on the held init_done; fill the buffer while still in CASET.
    wait_words(20);
    for (int i = 0; i < OVF_N - 1; i++) send_byte(8'h50 + 8'(i));
    check_eq("ovf_before_full", rx_overflow, 1'b0);
    send_byte(8'hEE);
    check_eq("ovf_set", rx_overflow, 1'b1);

    wait_words(31);
    for (int i = 0; i < 11; i++)
      if (19 + i < words.size()) check_eq($sformatf("hdr2_%0d", i), words[19 + i], hdr[i]);
    if (words.size() > 30) check_eq("first_kept", words[30], 9'h150);
    check_eq("ovf_sticky", rx_overflow, 1'b1);
    check_eq("multi_req", multi_req, 0);
    check_eq("unstable", unstable, 0);

    // Reset mid-PIXEL with init_done still high.
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    check_eq("mid_rst_data", show_pic_data, 9'h000);
    check_eq("mid_rst_en", en_write_show_pic, 1'b0);
    check_eq("mid_rst_done", show_pic_done, 1'b0);
    check_eq("mid_rst_ovf", rx_overflow, 1'b0);
    ack_delay = 0;
    repeat (3) @(negedge sys_clk);
    n = words.size();
    sys_rst_n = 1'b1;
    wait_words(n + 1);
    if (words.size() > n) check_eq("restart_caset", words[n], 9'h02A);
    check_eq("done_total", done_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
